clk_int_div_multi: RTL and testbench

CLK_INT_DIV_MULTI -- requirements
Module: clk_int_div_multi

---
 rtl/clk_int_div_multi.sv | 135 +++++++++++++
 tb/tb_clk_int_div_multi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/clk_int_div_multi.sv
// Multi-channel integer clock divider with valid/ready ratio loading.
// Optional settle counter on div_done_o: define CLK_INT_DIV_MULTI_DONE_EN.
module clk_int_div_multi #(
   parameter int NUM_CH           = 2,
   parameter int DIV_VALUE_WIDTH  = 8,
   parameter int DONE_DELAY_WIDTH = 3
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_CH-1:0]                 en_i,
   input  logic [NUM_CH*DIV_VALUE_WIDTH-1:0] div_i,
   input  logic [NUM_CH-1:0]                 div_valid_i,
   output logic [NUM_CH-1:0]                 div_ready_o,
   output logic [NUM_CH-1:0]                 div_done_o,
   output logic [NUM_CH-1:0]                 clk_o
);

   localparam int W = DIV_VALUE_WIDTH;

   typedef enum logic {OFF, RUN} state_e;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      state_e         state_q, state_d;
      logic [W-1:0]   div_q, div_d;
      logic [W-1:0]   pend_q, pend_d;
      logic [W-1:0]   cnt_q, cnt_d;
      logic           pend_vld_q, pend_vld_d;
      logic           clk_q, clk_d;
      logic [W-1:0]   div_in, div_clamp;
      logic [W:0]     half;
      logic           acc, wrap, div_wr;

      assign div_in    = div_i[k*W +: W];
      assign div_clamp = (div_in == '0) ? {{(W-1){1'b0}}, 1'b1} : div_in;
      assign acc       = div_valid_i[k] & ~pend_vld_q;
      assign wrap      = (cnt_q == div_q);
      assign half      = ({1'b0, div_q} + 1'b1) >> 1;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q    <= OFF;
            div_q      <= {{(W-1){1'b0}}, 1'b1};
            pend_q     <= {{(W-1){1'b0}}, 1'b1};
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            clk_q      <= 1'b0;
         end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
         end
      end

      // OFF leaves on any enabled edge, RUN only at a period wrap
      always_comb begin
         state_d = state_q;
         unique case (state_q)
            OFF: if (en_i[k]) state_d = RUN;
            RUN: if (wrap && !en_i[k]) state_d = OFF;
         endcase
      end

      always_comb begin
         div_d      = div_q;
         pend_d     = pend_q;
         pend_vld_d = pend_vld_q;
         cnt_d      = cnt_q;
         clk_d      = clk_q;
         div_wr     = 1'b0;
         unique case (state_q)
            OFF: begin
               if (acc) begin
                  div_d  = div_clamp;
                  div_wr = 1'b1;
               end
               if (en_i[k]) begin
                  cnt_d = '0;
                  clk_d = 1'b1;
               end
            end
            RUN: begin
               if (acc) begin
                  pend_d     = div_clamp;
                  pend_vld_d = 1'b1;
               end
               if (wrap) begin
                  // a ratio accepted on the wrap edge itself applies at once
                  if (pend_vld_q) begin
                     div_d      = pend_q;
                     pend_vld_d = 1'b0;
                     div_wr     = 1'b1;
                  end else if (acc) begin
                     div_d      = div_clamp;
                     pend_vld_d = 1'b0;
                     div_wr     = 1'b1;
                  end
                  cnt_d = '0;
                  clk_d = en_i[k];
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  clk_d = ({1'b0, cnt_d} < half);
               end
            end
         endcase
      end

`ifdef CLK_INT_DIV_MULTI_DONE_EN
      logic [DONE_DELAY_WIDTH-1:0] settle_q, settle_d;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) settle_q <= '0;
         else       settle_q <= settle_d;
      end

      always_comb begin
         settle_d = settle_q;
         if (div_wr)
            settle_d = '0;
         else if (state_q == RUN && wrap && !(&settle_q))
            settle_d = settle_q + 1'b1;
      end

      assign div_done_o[k] = &settle_q;
`else
      assign div_done_o[k] = ~pend_vld_q;
`endif

      assign div_ready_o[k] = ~pend_vld_q;
      assign clk_o[k]       = clk_q;
   end

endmodule

// File: tb/tb_clk_int_div_multi.sv
// Directed bench for clk_int_div_multi (default build, NUM_CH=2, W=8).
// Table-driven per-cycle vectors plus hand-written corner sequences.
module tb_clk_int_div_multi;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  en_i;
   logic [15:0] div_i;
   logic [1:0]  div_valid_i;
   logic [1:0]  div_ready_o;
   logic [1:0]  div_done_o;
   logic [1:0]  clk_o;

   int checks = 0;
   int errors = 0;

   clk_int_div_multi #(
      .NUM_CH(2),
      .DIV_VALUE_WIDTH(8),
      .DONE_DELAY_WIDTH(3)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .en_i(en_i),
      .div_i(div_i),
      .div_valid_i(div_valid_i),
      .div_ready_o(div_ready_o),
      .div_done_o(div_done_o),
      .clk_o(clk_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  en;
      logic [15:0] div;
      logic [1:0]  vld;
      logic [1:0]  clk;
      logic [1:0]  rdy;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string name, input logic [1:0] act,
                      input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] en, input logic [15:0] dv,
                       input logic [1:0] vld);
      en_i        = en;
      div_i       = dv;
      div_valid_i = vld;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_out(input string name, input logic [1:0] c,
                          input logic [1:0] r);
      chk({name, "_clk"}, clk_o, c);
      chk({name, "_rdy"}, div_ready_o, r);
`ifndef CLK_INT_DIV_MULTI_DONE_EN
      chk({name, "_done"}, div_done_o, r);
`endif
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      en_i        = '0;
      div_i       = '0;
      div_valid_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      logic [1:0] seq_a [8];
      logic [1:0] seq_b [6];

      tbl[0]  = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[1]  = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[2]  = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[3]  = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[4]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[5]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[6]  = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[7]  = '{2'b00, 16'h0003, 2'b01, 2'b00, 2'b11};
      tbl[8]  = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[9]  = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[10] = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[11] = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[12] = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[13] = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[14] = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[15] = '{2'b01, 16'h0004, 2'b01, 2'b00, 2'b10};
      tbl[16] = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[17] = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};
      tbl[18] = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[19] = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[20] = '{2'b01, 16'h0000, 2'b00, 2'b00, 2'b11};
      tbl[21] = '{2'b01, 16'h0000, 2'b00, 2'b01, 2'b11};

      do_reset();
      chk_out("reset", 2'b00, 2'b11);

      // default ratio, disable at wrap, OFF load, mid-period reload
      for (int i = 0; i < 22; i++) begin
         step(tbl[i].en, tbl[i].div, tbl[i].vld);
         chk_out($sformatf("vec%0d", i), tbl[i].clk, tbl[i].rdy);
      end

      // div=0 while OFF clamps to 1
      do_reset();
      step(2'b00, 16'h0000, 2'b01);
      chk_out("clamp_load", 2'b00, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("clamp_c0", 2'b01, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("clamp_c1", 2'b00, 2'b11);
      // accept on the wrap edge: ratio 3 applies immediately
      step(2'b01, 16'h0003, 2'b01);
      chk_out("wrapacc_c0", 2'b01, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("wrapacc_c1", 2'b01, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("wrapacc_c2", 2'b00, 2'b11);

      // ch1 N=6, enable dropped after one edge: full 3/3 period
      do_reset();
      step(2'b00, 16'h0500, 2'b10);
      chk_out("n6_load", 2'b00, 2'b11);
      seq_a = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      step(2'b10, 16'h0000, 2'b00);
      chk_out("n6_c0", seq_a[0], 2'b11);
      for (int i = 1; i < 8; i++) begin
         step(2'b00, 16'h0000, 2'b00);
         chk_out($sformatf("n6_c%0d", i), seq_a[i], 2'b11);
      end
      step(2'b10, 16'h0000, 2'b00);
      chk_out("n6_re0", 2'b10, 2'b11);
      step(2'b10, 16'h0000, 2'b00);
      chk_out("n6_re1", 2'b10, 2'b11);

      // two channels div 2 / div 5, async reset mid-period
      do_reset();
      step(2'b00, 16'h0502, 2'b11);
      chk_out("two_load", 2'b00, 2'b11);
      seq_b = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 6; i++) begin
         step(2'b11, 16'h0000, 2'b00);
         chk_out($sformatf("two_c%0d", i), seq_b[i], 2'b11);
      end
      step(2'b11, 16'h0000, 2'b00);
      chk_out("two_pre_rst", 2'b11, 2'b11);
      #2 rst_i = 1'b1;
      #1;
      chk_out("async_rst", 2'b00, 2'b11);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      chk_out("rst_hold", 2'b00, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("post_rst_c0", 2'b01, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("post_rst_c1", 2'b00, 2'b11);
      step(2'b01, 16'h0000, 2'b00);
      chk_out("post_rst_c2", 2'b01, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
